// File: rtl/rou_msg_pkg.sv
// Shared definitions for the roubus message serializer: command encodings,
// field offsets and width helpers.
package rou_msg_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_RMW   = 2'b11;

  // Fields are packed LSB-first as cmd, tags, bytes, addr, data.
  localparam int CMD_LSB = 0;
  localparam int TAG_LSB = 2;

  function automatic int bytes_lsb(input int twid);
    return TAG_LSB + twid;
  endfunction

  function automatic int addr_lsb(input int twid, input int bwid);
    return TAG_LSB + twid + bwid;
  endfunction

  function automatic int data_lsb(input int twid, input int bwid, input int awid);
    return TAG_LSB + twid + bwid + awid;
  endfunction

  function automatic int bwid_of(input int dwid);
    case (dwid)
      512:     return 6;
      256:     return 5;
      128:     return 4;
      64:      return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_SEND
  } ser_state_t;

endpackage

// File: rtl/rou_msg_serializer_if.sv
// Field-input and flit-output link of the roubus message serializer.
interface rou_msg_serializer_if
  import rou_msg_pkg::*;
#(
  parameter int DWID = 128,
  parameter int AWID = 32,
  parameter int TWID = 5,
  parameter int FWID = 32
);
  localparam int BWID = bwid_of(DWID);

  logic            in_valid;
  logic            in_ready;
  logic [DWID-1:0] data;
  logic [AWID-1:0] addr;
  logic [BWID-1:0] bytes;
  logic [TWID-1:0] tags;
  logic [1:0]      cmd;
  logic            out_valid;
  logic            out_ready;
  logic [FWID-1:0] out_flit;
  logic            out_first;
  logic            out_last;

  modport slave (
    input  in_valid, data, addr, bytes, tags, cmd, out_ready,
    output in_ready, out_valid, out_flit, out_first, out_last
  );

  modport master (
    output in_valid, data, addr, bytes, tags, cmd, out_ready,
    input  in_ready, out_valid, out_flit, out_first, out_last
  );

endinterface

// File: rtl/rou_msg_pack.sv
// Combinational packer: assembles the roubus message from its fields and
// zeroes the data payload for header-only (read) commands.
module rou_msg_pack
  import rou_msg_pkg::*;
#(
  parameter int DWID = 128,
  parameter int AWID = 32,
  parameter int TWID = 5,
  parameter int BWID = 4,
  parameter int WID  = 2 + DWID + AWID + BWID + TWID
) (
  input  logic [DWID-1:0] data,
  input  logic [AWID-1:0] addr,
  input  logic [BWID-1:0] bytes,
  input  logic [TWID-1:0] tags,
  input  logic [1:0]      cmd,
  output logic [WID-1:0]  msg,
  output logic            hdr_only
);
  localparam int BLSB = bytes_lsb(TWID);
  localparam int ALSB = addr_lsb(TWID, BWID);
  localparam int DLSB = data_lsb(TWID, BWID, AWID);

  assign hdr_only = (cmd == CMD_READ);

  // Reads leave the data region at zero so no payload bits reach the link.
  always_comb begin
    msg                  = '0;
    msg[CMD_LSB +: 2]    = cmd;
    msg[TAG_LSB +: TWID] = tags;
    msg[BLSB +: BWID]    = bytes;
    msg[ALSB +: AWID]    = addr;
    if (!hdr_only) begin
      msg[DLSB +: DWID] = data;
    end
  end

endmodule

// File: rtl/rou_msg_serializer.sv
// Registers a packed roubus request and streams it out LSB-first as
// FWID-wide flits, sending only the header flits for reads.
module rou_msg_serializer
  import rou_msg_pkg::*;
#(
  parameter int DWID = 128,
  parameter int AWID = 32,
  parameter int TWID = 5,
  parameter int FWID = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  rou_msg_serializer_if.slave bus
);
  localparam int BWID  = bwid_of(DWID);
  localparam int WID   = 2 + DWID + AWID + BWID + TWID;
  localparam int HWID  = 2 + TWID + BWID + AWID;
  localparam int NFLIT = ceil_div(WID, FWID);
  localparam int HFLIT = ceil_div(HWID, FWID);
  localparam int IWID  = (NFLIT > 1) ? $clog2(NFLIT) : 1;
  localparam int PWID  = NFLIT * FWID;
  localparam logic [IWID-1:0] NLAST = IWID'(NFLIT - 1);
  localparam logic [IWID-1:0] HLAST = IWID'(HFLIT - 1);

  logic [WID-1:0]  msg;
  logic            hdr_only;
  ser_state_t      state_q, state_d;
  logic [IWID-1:0] idx_q, idx_d;
  logic [IWID-1:0] last_q, last_d;
  logic [PWID-1:0] buf_q, buf_d;
  logic            in_ready, out_valid, out_first, out_last;
  logic [FWID-1:0] out_flit;

  rou_msg_pack #(
    .DWID(DWID), .AWID(AWID), .TWID(TWID), .BWID(BWID), .WID(WID)
  ) u_pack (
    .data(bus.data), .addr(bus.addr), .bytes(bus.bytes), .tags(bus.tags),
    .cmd(bus.cmd), .msg(msg), .hdr_only(hdr_only)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      buf_q   <= buf_d;
    end
  end

  // A load on the last-flit handshake overrides the return to IDLE, giving
  // back-to-back messages with no bubble; everything is quiet during reset.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    buf_d     = buf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_flit  = '0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: in_ready = 1'b1;
        ST_SEND: begin
          out_valid = 1'b1;
          out_flit  = buf_q[int'(idx_q) * FWID +: FWID];
          out_first = (idx_q == '0);
          out_last  = (idx_q == last_q);
          if (bus.out_ready) begin
            if (out_last) begin
              idx_d    = '0;
              in_ready = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              idx_d = idx_q + IWID'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (bus.in_valid && in_ready) begin
        state_d = ST_SEND;
        idx_d   = '0;
        buf_d   = PWID'(msg);
        last_d  = hdr_only ? HLAST : NLAST;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_flit  = out_flit;
  assign bus.out_first = out_first;
  assign bus.out_last  = out_last;

endmodule

// File: tb/tb_rou_msg_serializer.sv
// Directed bench for rou_msg_serializer: default build plus FWID 8/64/171 builds.
module tb_rou_msg_serializer;
  import rou_msg_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] data;
  logic [31:0]  addr;
  logic [3:0]   bytes;
  logic [4:0]   tags;
  logic [1:0]   cmd;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  rou_msg_serializer_if #(.FWID(32))  bus32 ();
  rou_msg_serializer_if #(.FWID(8))   bus8 ();
  rou_msg_serializer_if #(.FWID(64))  bus64 ();
  rou_msg_serializer_if #(.FWID(171)) bus171 ();

  assign bus32.in_valid  = in_valid;
  assign bus32.data      = data;
  assign bus32.addr      = addr;
  assign bus32.bytes     = bytes;
  assign bus32.tags      = tags;
  assign bus32.cmd       = cmd;
  assign bus32.out_ready = out_ready;
  assign bus8.in_valid   = in_valid;
  assign bus8.data       = data;
  assign bus8.addr       = addr;
  assign bus8.bytes      = bytes;
  assign bus8.tags       = tags;
  assign bus8.cmd        = cmd;
  assign bus8.out_ready  = out_ready;
  assign bus64.in_valid  = in_valid;
  assign bus64.data      = data;
  assign bus64.addr      = addr;
  assign bus64.bytes     = bytes;
  assign bus64.tags      = tags;
  assign bus64.cmd       = cmd;
  assign bus64.out_ready = out_ready;
  assign bus171.in_valid  = in_valid;
  assign bus171.data      = data;
  assign bus171.addr      = addr;
  assign bus171.bytes     = bytes;
  assign bus171.tags      = tags;
  assign bus171.cmd       = cmd;
  assign bus171.out_ready = out_ready;

  rou_msg_serializer #(.FWID(32))  dut32  (.clk(clk), .rst_n(rst_n), .bus(bus32));
  rou_msg_serializer #(.FWID(8))   dut8   (.clk(clk), .rst_n(rst_n), .bus(bus8));
  rou_msg_serializer #(.FWID(64))  dut64  (.clk(clk), .rst_n(rst_n), .bus(bus64));
  rou_msg_serializer #(.FWID(171)) dut171 (.clk(clk), .rst_n(rst_n), .bus(bus171));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [1:0] c, input logic [4:0] t,
                               input logic [3:0] b, input logic [31:0] a,
                               input logic [127:0] d);
    in_valid = v;
    cmd      = c;
    tags     = t;
    bytes    = b;
    addr     = a;
    data     = d;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [255:0] packMsg(input logic [127:0] d, input logic [31:0] a,
                                           input logic [3:0] b, input logic [4:0] t,
                                           input logic [1:0] c);
    return {85'd0, d, a, b, t, c};
  endfunction

  initial begin
    logic [127:0] data_a;
    logic [127:0] data_b;
    logic [255:0] exp_a;
    logic [255:0] exp_b;
    logic [31:0]  got [6];
    logic [11:0]  bp_pat;
    logic [255:0] reasm8, reasm64, reasm171;
    int           k, cnt8, cnt64, cnt171;

    data_a = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    data_b = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    exp_a  = packMsg(data_a, 32'h1000_0040, 4'hF, 5'h1A, CMD_WRITE);
    exp_b  = packMsg(data_b, 32'hCAFE_0000, 4'h3, 5'h05, CMD_WRITE);
    bp_pat = 12'b1111_1111_1001;

    rst_n     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 2'b00, '0, '0, '0, '0);

    // Reset state, with in_ready forced low while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("rst_in_ready", bus32.in_ready, 0);
    checkOutput("rst_out_valid", bus32.out_valid, 0);
    checkOutput("rst_out_first", bus32.out_first, 0);
    checkOutput("rst_out_last", bus32.out_last, 0);
    checkOutput("rst_out_flit", bus32.out_flit, 0);
    rst_n = 1'b1;

    // Full write: six flits on consecutive cycles.
    @(negedge clk);
    applyStimulus(1'b1, CMD_WRITE, 5'h1A, 4'hF, 32'h1000_0040, data_a);
    #1;
    checkOutput("idle_in_ready", bus32.in_ready, 1);
    checkOutput("idle_out_valid", bus32.out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, '0, '0, '0, '0);
      #1;
      got[i] = bus32.out_flit;
      checkOutput($sformatf("wr_valid%0d", i), bus32.out_valid, 1);
      checkOutput($sformatf("wr_flit%0d", i), bus32.out_flit, exp_a[i*32 +: 32]);
      checkOutput($sformatf("wr_first%0d", i), bus32.out_first, i == 0);
      checkOutput($sformatf("wr_last%0d", i), bus32.out_last, i == 5);
    end
    checkOutput("wr_flit0_hand", got[0], 32'h0002_07EA);
    checkOutput("wr_flit0_cmd", got[0][1:0], 2'b10);
    checkOutput("wr_flit0_tags", got[0][6:2], 5'h1A);
    checkOutput("wr_flit5_hand", got[5], 32'h0000_0009);
    @(negedge clk); #1;
    checkOutput("wr_done_valid", bus32.out_valid, 0);

    // Read: header only, data must not leak into flit 1.
    applyStimulus(1'b1, CMD_READ, 5'h03, 4'h0, 32'hDEAD_BEEF, {128{1'b1}});
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, '0, '0, '0, '0);
    #1;
    checkOutput("rd_flit0", bus32.out_flit, 32'h6DF7_780D);
    checkOutput("rd_first0", bus32.out_first, 1);
    checkOutput("rd_last0", bus32.out_last, 0);
    @(negedge clk); #1;
    checkOutput("rd_flit1", bus32.out_flit, 32'h0000_06F5);
    checkOutput("rd_last1", bus32.out_last, 1);
    @(negedge clk); #1;
    checkOutput("rd_done_valid", bus32.out_valid, 0);

    // Back-to-back: read A then write B with in_valid held.
    applyStimulus(1'b1, CMD_READ, 5'h03, 4'h0, 32'hDEAD_BEEF, {128{1'b1}});
    @(negedge clk);
    applyStimulus(1'b1, CMD_WRITE, 5'h05, 4'h3, 32'hCAFE_0000, data_b);
    #1;
    checkOutput("b2b_a0_flit", bus32.out_flit, 32'h6DF7_780D);
    checkOutput("b2b_a0_in_ready", bus32.in_ready, 0);
    @(negedge clk); #1;
    checkOutput("b2b_a1_last", bus32.out_last, 1);
    checkOutput("b2b_a1_in_ready", bus32.in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, '0, '0, '0, '0);
      #1;
      checkOutput($sformatf("b2b_b_valid%0d", i), bus32.out_valid, 1);
      checkOutput($sformatf("b2b_b_flit%0d", i), bus32.out_flit, exp_b[i*32 +: 32]);
      checkOutput($sformatf("b2b_b_first%0d", i), bus32.out_first, i == 0);
      if (i == 0) checkOutput("b2b_b_flit0_hand", bus32.out_flit, 32'hF000_0196);
    end
    @(negedge clk); #1;
    checkOutput("b2b_done_valid", bus32.out_valid, 0);

    // Backpressure: ready pattern 1,0,0,1,1... must replay the same flit order.
    applyStimulus(1'b1, CMD_WRITE, 5'h05, 4'h3, 32'hCAFE_0000, data_b);
    k = 0;
    for (int c = 0; c < 12 && k < 6; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, '0, '0, '0, '0);
      out_ready = bp_pat[c];
      #1;
      checkOutput($sformatf("bp_valid_c%0d", c), bus32.out_valid, 1);
      checkOutput($sformatf("bp_flit_c%0d", c), bus32.out_flit, exp_b[k*32 +: 32]);
      checkOutput($sformatf("bp_first_c%0d", c), bus32.out_first, k == 0);
      checkOutput($sformatf("bp_last_c%0d", c), bus32.out_last, k == 5);
      if (bp_pat[c]) k++;
    end
    checkOutput("bp_flit_count", k, 6);
    out_ready = 1'b1;
    @(negedge clk); #1;
    checkOutput("bp_done_valid", bus32.out_valid, 0);

    // Reset after flit 2 of a write, then a fresh read starts at flit 0.
    applyStimulus(1'b1, CMD_WRITE, 5'h1A, 4'hF, 32'h1000_0040, data_a);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, '0, '0, '0, '0);
      #1;
      checkOutput($sformatf("mr_flit%0d", i), bus32.out_flit, exp_a[i*32 +: 32]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_rst_in_ready", bus32.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, CMD_READ, 5'h03, 4'h0, 32'hDEAD_BEEF, {128{1'b1}});
    #1;
    checkOutput("mr_post_valid", bus32.out_valid, 0);
    checkOutput("mr_post_in_ready", bus32.in_ready, 1);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, '0, '0, '0, '0);
    #1;
    checkOutput("mr_fresh_flit0", bus32.out_flit, 32'h6DF7_780D);
    checkOutput("mr_fresh_first", bus32.out_first, 1);

    // Parameter sweep: FWID 8/64/171 reassemble to the packed message.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, CMD_WRITE, 5'h1A, 4'hF, 32'h1000_0040, data_a);
    reasm8 = '0;
    reasm64 = '0;
    reasm171 = '0;
    cnt8 = 0;
    cnt64 = 0;
    cnt171 = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, '0, '0, '0, '0);
      #1;
      if (bus8.out_valid) begin
        checkOutput($sformatf("sw8_first%0d", cnt8), bus8.out_first, cnt8 == 0);
        checkOutput($sformatf("sw8_last%0d", cnt8), bus8.out_last, cnt8 == 21);
        if (cnt8 < 32) reasm8[cnt8*8 +: 8] = bus8.out_flit;
        cnt8++;
      end
      if (bus64.out_valid) begin
        checkOutput($sformatf("sw64_last%0d", cnt64), bus64.out_last, cnt64 == 2);
        if (cnt64 < 4) reasm64[cnt64*64 +: 64] = bus64.out_flit;
        cnt64++;
      end
      if (bus171.out_valid) begin
        checkOutput("sw171_first_last", bus171.out_first && bus171.out_last, 1);
        reasm171[170:0] = bus171.out_flit;
        cnt171++;
      end
    end
    checkOutput("sw8_count", cnt8, 22);
    checkOutput("sw8_msg", reasm8, exp_a);
    checkOutput("sw64_count", cnt64, 3);
    checkOutput("sw64_msg", reasm64, exp_a);
    checkOutput("sw171_count", cnt171, 1);
    checkOutput("sw171_msg", reasm171, exp_a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
